// File: rtl/msg_deframer_if.sv
// Word-in / message-out bundle between a UART receiver side and the deframer.
// The master drives received words; the slave (deframer) drives results and status.
interface msg_deframer_if #(
    parameter int WORD_SIZE        = 8,
    parameter int WORDS_PER_PACKET = 4
);
    logic [WORD_SIZE-1:0]                  data_in;
    logic                                  data_in_valid;
    logic [WORD_SIZE*WORDS_PER_PACKET-1:0] data_out;
    logic                                  data_out_valid;
    logic                                  err_checksum;
    logic                                  err_timeout;
    logic [7:0]                            err_count;
    logic                                  busy;

    modport master (
        output data_in, data_in_valid,
        input  data_out, data_out_valid, err_checksum, err_timeout, err_count, busy
    );

    modport slave (
        input  data_in, data_in_valid,
        output data_out, data_out_valid, err_checksum, err_timeout, err_count, busy
    );
endinterface

// File: rtl/msg_deframer.sv
// Message deframer: SYNC word, fixed-length payload, XOR check word.
// Emits the last good payload, error strobes and a saturating reject counter.
module msg_deframer #(
    parameter int                   WORD_SIZE        = 8,
    parameter int                   WORDS_PER_PACKET = 4,
    parameter logic [WORD_SIZE-1:0] SYNC_WORD        = 8'hA5,
    parameter int                   TIMEOUT_CLKS     = 10800
) (
    input  logic            clk,
    input  logic            reset,
    msg_deframer_if.slave   bus
);
    localparam int PKT_W = WORD_SIZE * WORDS_PER_PACKET;
    localparam int IDX_W = (WORDS_PER_PACKET > 1) ? $clog2(WORDS_PER_PACKET) : 1;
    localparam int TMO_W = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_PACKET - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        IDLE,
        PAYLOAD,
        CHECK
    } state_t;

    state_t               state_reg;
    logic [IDX_W-1:0]     idx_reg;
    logic [TMO_W-1:0]     tmo_reg;
    logic [WORD_SIZE-1:0] xor_reg;
    logic [WORD_SIZE-1:0] payload_reg [WORDS_PER_PACKET];
    logic [PKT_W-1:0]     payload_packed;
    logic [PKT_W-1:0]     data_out_reg;
    logic                 data_out_valid_reg;
    logic                 err_checksum_reg;
    logic                 err_timeout_reg;
    logic [7:0]           err_count_reg;
    logic [7:0]           err_count_next;
    logic                 timeout_hit;

    // First received word lands in the MSBs of the message.
    generate
        for (genvar gi = 0; gi < WORDS_PER_PACKET; gi++) begin : g_pack
            assign payload_packed[(WORDS_PER_PACKET-1-gi)*WORD_SIZE +: WORD_SIZE] = payload_reg[gi];
        end
    endgenerate

    assign err_count_next = (err_count_reg == 8'hFF) ? err_count_reg : err_count_reg + 8'd1;
    assign timeout_hit    = (tmo_reg == TMO_LAST);

    // Payload words need no reset: they only reach data_out after a full, checked frame.
    always_ff @(posedge clk) begin
        if (state_reg == PAYLOAD && bus.data_in_valid) begin
            payload_reg[idx_reg] <= bus.data_in;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg          <= IDLE;
            idx_reg            <= '0;
            tmo_reg            <= '0;
            xor_reg            <= '0;
            data_out_reg       <= '0;
            data_out_valid_reg <= 1'b0;
            err_checksum_reg   <= 1'b0;
            err_timeout_reg    <= 1'b0;
            err_count_reg      <= '0;
        end else begin
            data_out_valid_reg <= 1'b0;
            err_checksum_reg   <= 1'b0;
            err_timeout_reg    <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (bus.data_in_valid && bus.data_in == SYNC_WORD) begin
                        state_reg <= PAYLOAD;
                        idx_reg   <= '0;
                        xor_reg   <= '0;
                        tmo_reg   <= '0;
                    end
                end
                PAYLOAD: begin
                    if (bus.data_in_valid) begin
                        xor_reg <= xor_reg ^ bus.data_in;
                        tmo_reg <= '0;
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= CHECK;
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end else if (timeout_hit) begin
                        err_timeout_reg <= 1'b1;
                        err_count_reg   <= err_count_next;
                        state_reg       <= IDLE;
                        tmo_reg         <= '0;
                    end else begin
                        tmo_reg <= tmo_reg + 1'b1;
                    end
                end
                CHECK: begin
                    // An arriving word always beats a timeout firing in the same cycle.
                    if (bus.data_in_valid) begin
                        if (bus.data_in == xor_reg) begin
                            data_out_reg       <= payload_packed;
                            data_out_valid_reg <= 1'b1;
                        end else begin
                            err_checksum_reg <= 1'b1;
                            err_count_reg    <= err_count_next;
                        end
                        state_reg <= IDLE;
                        tmo_reg   <= '0;
                    end else if (timeout_hit) begin
                        err_timeout_reg <= 1'b1;
                        err_count_reg   <= err_count_next;
                        state_reg       <= IDLE;
                        tmo_reg         <= '0;
                    end else begin
                        tmo_reg <= tmo_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.data_out       = data_out_reg;
    assign bus.data_out_valid = data_out_valid_reg;
    assign bus.err_checksum   = err_checksum_reg;
    assign bus.err_timeout    = err_timeout_reg;
    assign bus.err_count      = err_count_reg;
    assign bus.busy           = (state_reg != IDLE);
endmodule

// File: tb/tb_msg_deframer.sv
// Bench for msg_deframer: directed scenarios plus randomized frames against a
// frame-level reference model (payload packing, XOR check, saturating reject count).
module tb_msg_deframer;
    localparam int         WS   = 8;
    localparam int         WPP  = 4;
    localparam int         TO   = 100;
    localparam logic [7:0] SYNC = 8'hA5;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    msg_deframer_if #(.WORD_SIZE(WS), .WORDS_PER_PACKET(WPP)) bus ();

    msg_deframer #(
        .WORD_SIZE(WS), .WORDS_PER_PACKET(WPP), .SYNC_WORD(SYNC), .TIMEOUT_CLKS(TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Strobe monitor: counts pulses and flags overlapping or stretched strobes.
    int   mon_valid = 0, mon_cks = 0, mon_to = 0, mon_overlap = 0, mon_wide = 0;
    logic prev_dov = 1'b0, prev_cks = 1'b0, prev_to = 1'b0;
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.data_out_valid) mon_valid <= mon_valid + 1;
            if (bus.err_checksum)   mon_cks   <= mon_cks + 1;
            if (bus.err_timeout)    mon_to    <= mon_to + 1;
            if ((int'(bus.data_out_valid) + int'(bus.err_checksum) + int'(bus.err_timeout)) > 1)
                mon_overlap <= mon_overlap + 1;
            if ((bus.data_out_valid && prev_dov) || (bus.err_checksum && prev_cks) ||
                (bus.err_timeout && prev_to))
                mon_wide <= mon_wide + 1;
        end
        prev_dov <= bus.data_out_valid;
        prev_cks <= bus.err_checksum;
        prev_to  <= bus.err_timeout;
    end

    // Reference state: last good message and reject count.
    logic [31:0] exp_data = '0;
    int          exp_cnt  = 0;

    function automatic int sat_inc(input int c);
        return (c >= 255) ? 255 : c + 1;
    endfunction

    function automatic logic [7:0] xor_words(input logic [31:0] p);
        logic [7:0] x = '0;
        for (int i = 0; i < WPP; i++) x ^= p[i*8 +: 8];
        return x;
    endfunction

    // Called at a negedge; returns at the negedge after the word is captured.
    task automatic drive_word(input logic [7:0] w);
        bus.data_in       = w;
        bus.data_in_valid = 1'b1;
        @(negedge clk);
        bus.data_in_valid = 1'b0;
        bus.data_in       = 8'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sync, payload (first word = MSBs), check word; random gaps up to maxgap.
    task automatic send_frame(input logic [31:0] p, input logic [7:0] chk, input int maxgap);
        drive_word(SYNC);
        for (int i = WPP - 1; i >= 0; i--) begin
            idle($urandom_range(maxgap, 0));
            drive_word(p[i*8 +: 8]);
        end
        idle($urandom_range(maxgap, 0));
        drive_word(chk);
    endtask

    task automatic test_reset();
        bus.data_in = '0;
        bus.data_in_valid = 1'b0;
        reset = 1'b1;
        idle(3);
        n_cmp++;
        if (bus.data_out !== 32'h0 || bus.data_out_valid !== 1'b0 || bus.err_checksum !== 1'b0 ||
            bus.err_timeout !== 1'b0 || bus.err_count !== 8'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got out=%h v=%b ck=%b to=%b cnt=%0d busy=%b, need all 0",
                     bus.data_out, bus.data_out_valid, bus.err_checksum, bus.err_timeout,
                     bus.err_count, bus.busy);
        end
        reset = 1'b0;
        idle(2);
        $display("test_reset: done");
    endtask

    task automatic test_good_frame();
        send_frame(32'h11223344, 8'h44, 0);
        exp_data = 32'h11223344;
        n_cmp++;
        if (bus.data_out_valid !== 1'b1 || bus.data_out !== exp_data || bus.err_count !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL good_frame: got v=%b out=%h cnt=%0d, need v=1 out=%h cnt=%0d",
                     bus.data_out_valid, bus.data_out, bus.err_count, exp_data, exp_cnt);
        end
        idle(1);
        n_cmp++;
        if (bus.data_out_valid !== 1'b0 || bus.data_out !== exp_data || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL good_frame_after: got v=%b out=%h busy=%b, need v=0 out=%h busy=0",
                     bus.data_out_valid, bus.data_out, bus.busy, exp_data);
        end
        $display("test_good_frame: out=%h", bus.data_out);
    endtask

    task automatic test_bad_checksum();
        int v0 = mon_valid;
        send_frame(32'h11223344, 8'h45, 0);
        exp_cnt = sat_inc(exp_cnt);
        n_cmp++;
        if (bus.err_checksum !== 1'b1 || bus.data_out_valid !== 1'b0 ||
            bus.data_out !== exp_data || bus.err_count !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL bad_checksum: got ck=%b v=%b out=%h cnt=%0d, need ck=1 v=0 out=%h cnt=%0d",
                     bus.err_checksum, bus.data_out_valid, bus.data_out, bus.err_count, exp_data, exp_cnt);
        end
        idle(2);
        #1;
        n_cmp++;
        if (bus.err_checksum !== 1'b0 || mon_valid !== v0) begin
            n_fail++;
            $display("FAIL bad_checksum_after: got ck=%b valid_pulses=%0d, need ck=0 valid_pulses=%0d",
                     bus.err_checksum, mon_valid, v0);
        end
        $display("test_bad_checksum: cnt=%0d", bus.err_count);
    endtask

    task automatic test_timeout();
        drive_word(SYNC);
        drive_word(8'h11);
        idle(TO - 1);
        n_cmp++;
        if (bus.err_timeout !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_early: got to=%b busy=%b after %0d idle, need to=0 busy=1",
                     bus.err_timeout, bus.busy, TO - 1);
        end
        idle(1);
        exp_cnt = sat_inc(exp_cnt);
        n_cmp++;
        if (bus.err_timeout !== 1'b1 || bus.busy !== 1'b0 || bus.err_count !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL timeout_fire: got to=%b busy=%b cnt=%0d, need to=1 busy=0 cnt=%0d",
                     bus.err_timeout, bus.busy, bus.err_count, exp_cnt);
        end
        idle(1);
        send_frame(32'hDEADBEEF, xor_words(32'hDEADBEEF), 1);
        exp_data = 32'hDEADBEEF;
        n_cmp++;
        if (bus.data_out_valid !== 1'b1 || bus.data_out !== exp_data) begin
            n_fail++;
            $display("FAIL timeout_recover: got v=%b out=%h, need v=1 out=%h",
                     bus.data_out_valid, bus.data_out, exp_data);
        end
        $display("test_timeout: cnt=%0d", bus.err_count);
    endtask

    task automatic test_word_beats_timeout();
        int t0 = mon_to;
        drive_word(SYNC);
        drive_word(8'h11);
        idle(TO - 1);
        drive_word(8'h22);
        drive_word(8'h33);
        drive_word(8'h44);
        idle(TO - 1);
        drive_word(8'h44);
        exp_data = 32'h11223344;
        n_cmp++;
        if (bus.data_out_valid !== 1'b1 || bus.data_out !== exp_data) begin
            n_fail++;
            $display("FAIL word_beats_timeout: got v=%b out=%h, need v=1 out=%h",
                     bus.data_out_valid, bus.data_out, exp_data);
        end
        idle(1);
        #1;
        n_cmp++;
        if (mon_to !== t0) begin
            n_fail++;
            $display("FAIL word_beats_timeout_pulses: got %0d timeouts, need %0d", mon_to, t0);
        end
        $display("test_word_beats_timeout: out=%h", bus.data_out);
    endtask

    task automatic test_garbage();
        int c0 = mon_cks, t0 = mon_to;
        drive_word(8'h00);
        drive_word(8'hFF);
        drive_word(8'h5A);
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL garbage_idle: got busy=%b, need 0", bus.busy);
        end
        send_frame(32'hA5A5A5A5, 8'h00, 0);
        exp_data = 32'hA5A5A5A5;
        idle(1);
        #1;
        n_cmp++;
        if (bus.data_out !== exp_data || mon_cks !== c0 || mon_to !== t0 || bus.err_count !== 8'(exp_cnt)) begin
            n_fail++;
            $display("FAIL garbage: got out=%h cks=%0d to=%0d cnt=%0d, need out=%h cks=%0d to=%0d cnt=%0d",
                     bus.data_out, mon_cks, mon_to, bus.err_count, exp_data, c0, t0, exp_cnt);
        end
        $display("test_garbage: out=%h", bus.data_out);
    endtask

    task automatic test_back_to_back();
        int v0 = mon_valid;
        send_frame(32'h01020304, xor_words(32'h01020304), 0);
        send_frame(32'hCAFEF00D, xor_words(32'hCAFEF00D), 0);
        exp_data = 32'hCAFEF00D;
        idle(1);
        #1;
        n_cmp++;
        if (bus.data_out !== exp_data || mon_valid !== v0 + 2) begin
            n_fail++;
            $display("FAIL back_to_back: got out=%h pulses=%0d, need out=%h pulses=%0d",
                     bus.data_out, mon_valid - v0, exp_data, 2);
        end
        $display("test_back_to_back: out=%h", bus.data_out);
    endtask

    task automatic test_random();
        int v0 = mon_valid, c0 = mon_cks, t0 = mon_to;
        int ev = 0, ec = 0, et = 0;
        for (int f = 0; f < 40; f++) begin
            int kind = $urandom_range(2, 0);
            for (int g = $urandom_range(2, 0); g > 0; g--) begin
                logic [7:0] w = 8'($urandom);
                if (w == SYNC) w = 8'h00;
                drive_word(w);
            end
            if (kind == 2) begin
                int m = $urandom_range(WPP, 0);
                drive_word(SYNC);
                for (int i = 0; i < m; i++) drive_word(8'($urandom));
                idle(TO + 2);
                et++;
                exp_cnt = sat_inc(exp_cnt);
                n_cmp++;
                if (bus.busy !== 1'b0 || bus.err_count !== 8'(exp_cnt)) begin
                    n_fail++;
                    $display("FAIL random_timeout[%0d]: got busy=%b cnt=%0d, need busy=0 cnt=%0d",
                             f, bus.busy, bus.err_count, exp_cnt);
                end
            end else begin
                logic [31:0] p   = $urandom;
                logic [7:0]  chk = xor_words(p);
                if (kind == 1) chk ^= 8'($urandom_range(255, 1));
                send_frame(p, chk, 3);
                if (kind == 0) begin
                    ev++;
                    exp_data = p;
                end else begin
                    ec++;
                    exp_cnt = sat_inc(exp_cnt);
                end
                n_cmp++;
                if (bus.data_out_valid !== (kind == 0) || bus.err_checksum !== (kind == 1) ||
                    bus.data_out !== exp_data || bus.err_count !== 8'(exp_cnt)) begin
                    n_fail++;
                    $display("FAIL random_frame[%0d]: got v=%b ck=%b out=%h cnt=%0d, need v=%b ck=%b out=%h cnt=%0d",
                             f, bus.data_out_valid, bus.err_checksum, bus.data_out, bus.err_count,
                             kind == 0, kind == 1, exp_data, exp_cnt);
                end
            end
            $display("random frame %0d kind=%0d out=%h cnt=%0d", f, kind, bus.data_out, bus.err_count);
        end
        idle(2);
        #1;
        n_cmp++;
        if (mon_valid - v0 !== ev || mon_cks - c0 !== ec || mon_to - t0 !== et) begin
            n_fail++;
            $display("FAIL random_totals: got v=%0d ck=%0d to=%0d, need v=%0d ck=%0d to=%0d",
                     mon_valid - v0, mon_cks - c0, mon_to - t0, ev, ec, et);
        end
        n_cmp++;
        if (mon_overlap !== 0 || mon_wide !== 0) begin
            n_fail++;
            $display("FAIL strobe_shape: got overlap=%0d wide=%0d, need 0 and 0", mon_overlap, mon_wide);
        end
    endtask

    task automatic test_saturation();
        for (int f = 0; f < 260; f++) begin
            logic [31:0] p = $urandom;
            send_frame(p, xor_words(p) ^ 8'h01, 0);
            exp_cnt = sat_inc(exp_cnt);
            n_cmp++;
            if (bus.err_count !== 8'(exp_cnt) || bus.data_out !== exp_data) begin
                n_fail++;
                $display("FAIL saturation[%0d]: got cnt=%0d out=%h, need cnt=%0d out=%h",
                         f, bus.err_count, bus.data_out, exp_cnt, exp_data);
            end
        end
        $display("test_saturation: cnt=%0d", bus.err_count);
    endtask

    task automatic test_reset_mid_frame();
        int t0, c0;
        drive_word(SYNC);
        drive_word(8'h77);
        #3 reset = 1'b1;
        #1;
        n_cmp++;
        if (bus.data_out !== 32'h0 || bus.err_count !== 8'd0 || bus.busy !== 1'b0 ||
            bus.data_out_valid !== 1'b0 || bus.err_checksum !== 1'b0 || bus.err_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got out=%h cnt=%0d busy=%b v=%b ck=%b to=%b, need all 0",
                     bus.data_out, bus.err_count, bus.busy, bus.data_out_valid,
                     bus.err_checksum, bus.err_timeout);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = 0;
        exp_data = '0;
        #1;
        t0 = mon_to;
        c0 = mon_cks;
        idle(TO + 5);
        #1;
        n_cmp++;
        if (mon_to !== t0 || mon_cks !== c0 || bus.err_count !== 8'd0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_discard: got to=%0d ck=%0d cnt=%0d busy=%b, need to=%0d ck=%0d cnt=0 busy=0",
                     mon_to, mon_cks, bus.err_count, bus.busy, t0, c0);
        end
        @(negedge clk);
        send_frame(32'h0BADF00D, xor_words(32'h0BADF00D), 0);
        exp_data = 32'h0BADF00D;
        n_cmp++;
        if (bus.data_out_valid !== 1'b1 || bus.data_out !== exp_data) begin
            n_fail++;
            $display("FAIL reset_recover: got v=%b out=%h, need v=1 out=%h",
                     bus.data_out_valid, bus.data_out, exp_data);
        end
        $display("test_reset_mid_frame: out=%h", bus.data_out);
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_timeout();
        test_word_beats_timeout();
        test_garbage();
        test_back_to_back();
        test_random();
        test_saturation();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
